// File: rtl/colour_zone_tracker.sv
// colour_zone_tracker: per-frame target-colour zone histogram with winner select and multi-frame hysteresis
module colour_zone_tracker #(
   parameter int H_ACTIVE = 640,
   parameter int NUM_ZONES = 5,
   parameter int COUNT_W = 17,
   parameter int MIN_PIXELS = 200,
   parameter int CONFIRM_FRAMES = 3,
   parameter int R_MIN = 180,
   parameter int G_MAX = 140,
   parameter int B_MAX = 90,
   localparam int DIR_W = $clog2(NUM_ZONES)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic               vsync,
   input  logic [7:0]         red,
   input  logic [7:0]         green,
   input  logic [7:0]         blue,
   input  logic               ext_mask,
   input  logic               use_ext_mask,
   output logic [DIR_W-1:0]   zone_idx,
   output logic [COUNT_W-1:0] zone_count,
   output logic               detected,
   output logic               result_valid
);
   localparam int ZONE_W = H_ACTIVE / NUM_ZONES;
   localparam int CW = ZONE_W > 1 ? $clog2(ZONE_W) : 1;
   localparam int SW = $clog2(CONFIRM_FRAMES + 1);
   typedef enum logic [1:0] {ACCUM, SCAN, DECIDE} state_t;
   state_t state, state_nx;
   logic vs_q, vs_q1, vs_fall, pix_hit, last_scan, hit;
   logic accum_en, scan_en, decide_en;
   logic [CW-1:0] col_in_zone;
   logic [DIR_W-1:0] zone_ptr, scan_idx, best_idx;
   logic [COUNT_W-1:0] acc [NUM_ZONES];
   logic [COUNT_W-1:0] best_count;
   logic [SW-1:0] hit_streak, miss_streak, hit_nx, miss_nx;
   assign pix_hit = pix_valid & (use_ext_mask ? ext_mask :
                    (red >= 8'(R_MIN) && green <= 8'(G_MAX) && blue <= 8'(B_MAX)));
   assign vs_fall = vs_q1 & ~vs_q;
   assign last_scan = scan_idx == DIR_W'(NUM_ZONES - 1);
   assign hit = 32'(best_count) >= 32'(MIN_PIXELS);
   assign hit_nx = hit_streak == SW'(CONFIRM_FRAMES) ? hit_streak : hit_streak + 1'b1;
   assign miss_nx = miss_streak == SW'(CONFIRM_FRAMES) ? miss_streak : miss_streak + 1'b1;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= ACCUM;
      else state <= state_nx;
   always_comb
      state_nx = state == ACCUM ? (vs_fall ? SCAN : ACCUM) :
                 state == SCAN ? (last_scan ? DECIDE : SCAN) : ACCUM;
   always_comb begin
      accum_en = state == ACCUM;
      scan_en = state == SCAN;
      decide_en = state == DECIDE;
   end
   // Column position resets on any pix_valid gap; the last zone absorbs leftover pixels.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vs_q <= 1'b0;
         vs_q1 <= 1'b0;
         col_in_zone <= '0;
         zone_ptr <= '0;
      end else begin
         vs_q <= vsync;
         vs_q1 <= vs_q;
         col_in_zone <= (!pix_valid || col_in_zone == CW'(ZONE_W - 1)) ? '0 : col_in_zone + 1'b1;
         zone_ptr <= !pix_valid ? '0 :
                     (col_in_zone == CW'(ZONE_W - 1) && zone_ptr != DIR_W'(NUM_ZONES - 1)) ? zone_ptr + 1'b1 : zone_ptr;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < NUM_ZONES; i++) acc[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ZONES; i++)
            if (decide_en) acc[i] <= '0;
            else if (accum_en && pix_hit && zone_ptr == DIR_W'(i) && acc[i] != '1) acc[i] <= acc[i] + 1'b1;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         scan_idx <= '0;
         best_idx <= '0;
         best_count <= '0;
         zone_idx <= DIR_W'(NUM_ZONES / 2);
         zone_count <= '0;
         detected <= 1'b0;
         result_valid <= 1'b0;
         hit_streak <= '0;
         miss_streak <= '0;
      end else begin
         result_valid <= decide_en;
         if (accum_en) begin
            scan_idx <= '0;
            best_idx <= '0;
            best_count <= '0;
         end
         if (scan_en) begin
            scan_idx <= scan_idx + 1'b1;
            if (acc[scan_idx] > best_count) begin
               best_count <= acc[scan_idx];
               best_idx <= scan_idx;
            end
         end
         if (decide_en) begin
            zone_count <= best_count;
            if (hit) zone_idx <= best_idx;
            hit_streak <= hit ? hit_nx : '0;
            miss_streak <= hit ? '0 : miss_nx;
            detected <= hit ? (detected | (hit_nx == SW'(CONFIRM_FRAMES))) :
                              (detected & (miss_nx != SW'(CONFIRM_FRAMES)));
         end
      end
endmodule

// File: tb/tb_colour_zone_tracker.sv
// tb_colour_zone_tracker: randomized and directed frames checked every cycle against a frame-level model
module tb_colour_zone_tracker;
   localparam int N = 5, HA = 10, ZW = HA / N, MINP = 4, CF = 2;
   logic clk = 0, reset = 1, pix_valid = 0, vsync = 1, ext_mask = 0, use_ext_mask = 1;
   logic [7:0] red = 0, green = 0, blue = 0;
   logic [2:0] zone_idx, zone_idx_s, zone_count_s;
   logic [16:0] zone_count;
   logic detected, detected_s, result_valid, result_valid_s;
   int vectors = 0, miscompares = 0;
   int cap [2] = '{131071, 7};
   int m_acc [2][N];
   int m_zone [2], m_count [2], m_hs [2], m_ms [2];
   bit m_det [2];
   bit m_rv, s_prev;
   int ph, pos;

   always #5 clk = ~clk;

   colour_zone_tracker #(.H_ACTIVE(HA), .NUM_ZONES(N), .COUNT_W(17), .MIN_PIXELS(MINP), .CONFIRM_FRAMES(CF)) dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .vsync(vsync), .red(red), .green(green), .blue(blue),
      .ext_mask(ext_mask), .use_ext_mask(use_ext_mask), .zone_idx(zone_idx), .zone_count(zone_count),
      .detected(detected), .result_valid(result_valid));

   colour_zone_tracker #(.H_ACTIVE(HA), .NUM_ZONES(N), .COUNT_W(3), .MIN_PIXELS(MINP), .CONFIRM_FRAMES(CF)) dut_s (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .vsync(vsync), .red(red), .green(green), .blue(blue),
      .ext_mask(ext_mask), .use_ext_mask(use_ext_mask), .zone_idx(zone_idx_s), .zone_count(zone_count_s),
      .detected(detected_s), .result_valid(result_valid_s));

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_zone[k] = N / 2;
         m_count[k] = 0;
         m_hs[k] = 0;
         m_ms[k] = 0;
         m_det[k] = 0;
         for (int i = 0; i < N; i++) m_acc[k][i] = 0;
      end
      m_rv = 0;
      s_prev = 0;
      ph = -1;
      pos = 0;
   endtask

   task automatic model_frame();
      for (int k = 0; k < 2; k++) begin
         int best, bi;
         best = 0;
         bi = 0;
         for (int i = 0; i < N; i++)
            if (m_acc[k][i] > best) begin
               best = m_acc[k][i];
               bi = i;
            end
         m_count[k] = best;
         if (best >= MINP) begin
            m_zone[k] = bi;
            m_hs[k] = m_hs[k] < CF ? m_hs[k] + 1 : CF;
            m_ms[k] = 0;
            if (m_hs[k] == CF) m_det[k] = 1;
         end else begin
            m_ms[k] = m_ms[k] < CF ? m_ms[k] + 1 : CF;
            m_hs[k] = 0;
            if (m_ms[k] == CF) m_det[k] = 0;
         end
         for (int i = 0; i < N; i++) m_acc[k][i] = 0;
      end
   endtask

   // ph counts clock edges since an accepted vsync fall; pixels count only up to one edge after it.
   task automatic model_step();
      bit hit_px;
      int z, ph_b;
      hit_px = use_ext_mask ? ext_mask : (red >= 180 && green <= 140 && blue <= 90);
      ph_b = ph;
      if (pix_valid) begin
         z = pos / ZW < N ? pos / ZW : N - 1;
         if (hit_px && ph_b <= 0)
            for (int k = 0; k < 2; k++)
               if (m_acc[k][z] < cap[k]) m_acc[k][z]++;
         pos++;
      end else pos = 0;
      m_rv = 0;
      if (ph >= 0) ph++;
      if (ph == N + 2) begin
         model_frame();
         ph = -1;
         m_rv = 1;
      end
      if (s_prev && !vsync && ph < 0) ph = 0;
      s_prev = vsync;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   always @(negedge clk) begin
      check("zone_idx", zone_idx, m_zone[0]);
      check("zone_count", zone_count, m_count[0]);
      check("detected", detected, m_det[0]);
      check("result_valid", result_valid, m_rv);
      check("sat zone_idx", zone_idx_s, m_zone[1]);
      check("sat zone_count", zone_count_s, m_count[1]);
      check("sat detected", detected_s, m_det[1]);
      check("sat result_valid", result_valid_s, m_rv);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic line(input logic [15:0] m, input int len = HA);
      for (int c = 0; c < len; c++) begin
         pix_valid = 1;
         ext_mask = m[c];
         tick();
      end
      pix_valid = 0;
      ext_mask = 0;
      repeat (2) tick();
   endtask

   task automatic frame_end(input bit glitch);
      int lat;
      lat = 0;
      vsync = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         if (glitch) vsync = (c == 3);
         tick();
         if (result_valid) lat = c;
      end
      check("latency", lat - 1, N + 2);
   endtask

   task automatic frame_gap();
      repeat (2) tick();
      vsync = 1;
      repeat (2) tick();
   endtask

   task automatic finish_frame(input int zi, input int zc, input bit det, input int zcs);
      frame_end(0);
      check("lit zone_idx", zone_idx, zi);
      check("lit zone_count", zone_count, zc);
      check("lit detected", detected, det);
      check("lit sat zone_count", zone_count_s, zcs);
      frame_gap();
   endtask

   task automatic frame_a();
      repeat (4) line(16'h00C0);
   endtask

   initial begin
      int pulses, p, nl, len;
      repeat (3) tick();
      check("reset zone_idx", zone_idx, 2);
      check("reset zone_count", zone_count, 0);
      check("reset detected", detected, 0);
      check("reset result_valid", result_valid, 0);
      reset = 0;
      tick();
      frame_a(); finish_frame(3, 8, 0, 7);
      frame_a(); finish_frame(3, 8, 1, 7);
      frame_a(); finish_frame(3, 8, 1, 7);
      repeat (2) line(16'h0000); finish_frame(3, 0, 1, 0);
      repeat (2) line(16'h0000); finish_frame(3, 0, 0, 0);
      line(16'h030C); line(16'h030C); line(16'h0104); finish_frame(1, 5, 0, 5);
      line(16'h0003); line(16'h0001); finish_frame(1, 3, 0, 3);
      use_ext_mask = 0; red = 200; green = 100; blue = 50;
      line(16'h5555); finish_frame(1, 2, 0, 2);
      use_ext_mask = 1; red = 0; green = 0; blue = 0;
      repeat (6) line(16'h0003); finish_frame(0, 12, 0, 7);
      frame_a();
      vsync = 0;
      repeat (3) tick();
      reset = 1;
      #1;
      check("scan reset zone_idx", zone_idx, 2);
      check("scan reset zone_count", zone_count, 0);
      check("scan reset detected", detected, 0);
      check("scan reset result_valid", result_valid, 0);
      tick();
      reset = 0;
      vsync = 1;
      pulses = 0;
      repeat (12) begin
         tick();
         pulses += int'(result_valid);
      end
      check("no pulse after reset", pulses, 0);
      frame_a(); finish_frame(3, 8, 0, 7);
      line(16'h1C00, 13); line(16'h1C00, 13); finish_frame(4, 6, 1, 6);
      for (int f = 0; f < 30; f++) begin
         use_ext_mask = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: p = 0;
            1: p = 15;
            2: p = 50;
            default: p = 90;
         endcase
         nl = $urandom_range(0, 6);
         for (int l = 0; l < nl; l++) begin
            len = $urandom_range(4, 13);
            for (int c = 0; c < len; c++) begin
               pix_valid = 1;
               ext_mask = $urandom_range(0, 99) < p;
               red = 8'($urandom_range(170, 190));
               green = 8'($urandom_range(130, 150));
               blue = 8'($urandom_range(80, 100));
               tick();
            end
            pix_valid = 0;
            ext_mask = 0;
            repeat ($urandom_range(1, 3)) tick();
         end
         frame_end(f % 4 == 1);
         frame_gap();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/colour_zone_tracker.md
Name: colour_zone_tracker

Overview:
- Parametrised successor to the single-target classifier in the camera display path.
- Sits on the 25 MHz VGA pixel stream after RGB decode.
- Per frame, counts target-coloured pixels in NUM_ZONES vertical strips and selects the winning strip, which the drive FSM uses as its direction.
- Confirms or releases detection with multi-frame hysteresis.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- NUM_ZONES, 5, number of horizontal zones (2..16).
- COUNT_W, 17, zone accumulator width; accumulators saturate.
- MIN_PIXELS, 200, minimum winning-zone count for a frame to count as a hit.
- CONFIRM_FRAMES, 3, consecutive hits to set detected, and consecutive misses to clear it.
- R_MIN / G_MAX / B_MAX, 180 / 140 / 90, internal colour mask thresholds.
- Derived: DIR_W = clog2(NUM_ZONES); ZONE_W = H_ACTIVE/NUM_ZONES (integer).

Ports:
- clk  in  1  pixel clock (25 MHz VGA domain).
- reset  in  1  asynchronous, active-high.
- pix_valid  in  1  active-area qualifier, one pixel per cycle while high.
- vsync  in  1  VGA vsync, active-low.
- red / green / blue  in  8 each  pixel colour.
- ext_mask  in  1  external per-pixel target flag (target_finder output).
- use_ext_mask  in  1  1 = use ext_mask; 0 = use internal threshold mask.
- zone_idx  out  DIR_W  winning zone, 0 = leftmost.
- zone_count  out  COUNT_W  count in winning zone for the last frame.
- detected  out  1  hysteresis-filtered target present.
- result_valid  out  1  one-cycle pulse when the frame result updates.

Behaviour:
- Reset values:
  - zone_idx = NUM_ZONES/2.
  - zone_count = 0, detected = 0, result_valid = 0.
  - All accumulators, streak counters and column counters = 0.
  - State = ACCUM.
- Mask:
  - Internal mask hit = red >= R_MIN && green <= G_MAX && blue <= B_MAX.
  - The selected mask is sampled with pix_valid in the same cycle.
- Column tracking:
  - col_in_zone and zone_ptr advance on each pix_valid cycle.
  - When col_in_zone == ZONE_W-1, col_in_zone wraps to 0 and zone_ptr increments, capped at NUM_ZONES-1. Leftover pixels from H_ACTIVE not dividing evenly land in the last zone.
  - pix_valid low for one or more cycles (line end) resets col_in_zone and zone_ptr to 0 before the next valid pixel.
- Accumulation (state ACCUM only):
  - When pix_valid and mask are both high, acc[zone_ptr] increments.
  - Accumulators saturate at 2^COUNT_W-1 with no wrap.
- Frame end:
  - vsync is registered; a 1->0 transition seen in ACCUM moves to SCAN on the next cycle.
  - A vsync edge seen in SCAN or DECIDE is ignored.
- SCAN (exactly NUM_ZONES cycles):
  - Index i = 0..NUM_ZONES-1; best updates when acc[i] > best_count (strict).
  - Ties go to the lowest index.
  - pix_valid is ignored during SCAN and DECIDE.
- DECIDE (1 cycle):
  - hit = best_count >= MIN_PIXELS.
  - On hit: zone_idx <= best_idx; zone_count <= best_count; hit_streak increments (saturating at CONFIRM_FRAMES); miss_streak <= 0.
  - On miss: zone_idx is held; zone_count <= best_count; miss_streak increments (saturating); hit_streak <= 0.
  - detected sets when hit_streak reaches CONFIRM_FRAMES and clears when miss_streak reaches CONFIRM_FRAMES; otherwise it is held.
  - All accumulators clear; result_valid pulses; state returns to ACCUM.
- Latency: result_valid is high exactly NUM_ZONES+2 cycles after the first clk edge on which registered vsync shows 0.
- Reset mid-frame or mid-SCAN: everything returns to reset values immediately, with no result_valid pulse. The first result after reset comes from the first full vsync falling edge.

Test Plan:
Bench parameters: H_ACTIVE=10, NUM_ZONES=5, MIN_PIXELS=4, CONFIRM_FRAMES=2, use_ext_mask=1.
- Reset check -> zone_idx=2, detected=0, zone_count=0, result_valid=0.
- Frame: 4 lines with ext_mask high only on columns 6-7 (zone 3), then vsync falling -> result_valid exactly 7 cycles later; zone_idx=3; zone_count=8; detected=0 (1 hit).
- Repeat the same frame -> detected=1 after the second result_valid; a third identical frame keeps detected=1.
- Two empty frames after detection -> zone_count=0, zone_idx stays 3; detected clears on the second empty frame.
- Tie: zones 1 and 4 each receive 5 hits -> zone_idx=1, zone_count=5. Frame with 3 hits in zone 0 only -> miss; zone_idx held; zone_count=3.
- use_ext_mask=0 with the internal mask, pixel (200,100,50) for a whole line -> zones 0-4 each get 2. Saturation run with COUNT_W=3 and 12 hits in zone 0 -> zone_count=7. Reset asserted during SCAN -> no result_valid, outputs return to reset values.
